// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte indexing and the SubBytes FSM encoding.
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;
    localparam int AES_BYTE_W  = 8;
    // Width of a byte index into the 16-byte state.
    localparam int AES_BIDX_W  = $clog2(AES_NBYTES);

    // Element 0 sits at the MSB, so state[i] is FIPS-197 byte i (bits [127-8i -: 8]).
    typedef logic [0:AES_NBYTES-1][AES_BYTE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } sb_state_e;
endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: 8-bit combinational lookup, fully populated (no default hole).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_i,
    output logic [AES_BYTE_W-1:0] byte_o
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX[byte_i];
endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Iterative SubBytes engine: LANES S-box lookups per cycle over a 16-byte state,
// valid/ready on both sides, result held in DONE until the consumer takes it.
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);
    localparam int NGRP  = AES_NBYTES / LANES;
    localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e                      state_q;
    aes_state_t                     work_q, work_d;
    logic [CNT_W-1:0]               cnt_q;
    logic                           in_ready_q, out_valid_q, busy_q;
    logic [AES_STATE_W-1:0]         out_q;
    logic [LANES-1:0][AES_BYTE_W-1:0] lane_in, lane_out;
    logic                           last_grp;

    assign last_grp  = (cnt_q == CNT_LAST);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_q;
    assign busy      = busy_q;

    // Lane mux: lane l reads byte cnt*LANES + l of the working state.
    always_comb begin
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[AES_BIDX_W'(int'(cnt_q) * LANES + l)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .byte_i (lane_in[g]),
            .byte_o (lane_out[g])
        );
    end

    // Working register next value: load on accept, write back the current group in PROC.
    always_comb begin
        work_d = work_q;
        if (state_q == IDLE) begin
            if (in_valid) work_d = in_state;
        end else if (state_q == PROC) begin
            for (int l = 0; l < LANES; l++) begin
                work_d[AES_BIDX_W'(int'(cnt_q) * LANES + l)] = lane_out[l];
            end
        end
    end

    // Control FSM with registered handshake outputs; result latched on PROC->DONE only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            work_q <= work_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= PROC;
                    end
                end
                PROC: begin
                    if (last_grp) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= work_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: vector table through a scoreboard on a LANES=4 instance,
// hand sequences for latency/backpressure/ignored input/reset, and a LANES sweep.
module tb_aes_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;

    logic         sw_in_valid, sw_out_ready;
    logic [127:0] sw_in_state;
    logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
    logic [127:0] sw_out_state [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int pushed = 0, popped = 0, flushed = 0;

    typedef struct { logic [127:0] in_s; logic [127:0] exp_s; } vec_t;
    vec_t sbq[$];
    vec_t vtab[18];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_sub_bytes_seq #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sw
        aes_sub_bytes_seq #(.LANES(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]),
            .in_state(sw_in_state), .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
            .out_state(sw_out_state[g]), .busy(sw_busy[g])
        );
    end

    // ---------------- reference model (GF(2^8) inverse + affine map) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;   // a^254; 0 maps to 0
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox_m(input logic [7:0] s);
        return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_m(input logic [127:0] s);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = sbox_m(s[127-8*j -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_m(input logic [127:0] s);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = inv_sbox_m(s[127-8*j -: 8]);
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard sink: a result is consumed on the edge after a negedge that sees valid&ready.
    always @(negedge clk) begin
        vec_t t;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: got %h expected no output", out_state);
            end else begin
                t = sbq.pop_front();
                popped++;
                chk("sb_out", out_state, t.exp_s);
                chk("sb_roundtrip", inv_sub_m(out_state), t.in_s);
            end
        end
    end

    task automatic send(input logic [127:0] s, input logic [127:0] e);
        int n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_state = s;
        sbq.push_back('{s, e});
        pushed++;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 300) begin @(posedge clk); #1; n++; end
        if (sbq.size() != 0 || !in_ready) begin
            checks++; errors++;
            $display("FAIL drain_timeout: queue=%0d in_ready=%b expected 0 and 1", sbq.size(), in_ready);
        end
    endtask

    function automatic int sw_ln(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, a1, bad;
        logic [127:0] snap;
        int sw_lat [4];
        logic [127:0] sw_res [4];
        int nacc [4];
        int acc [4][2];

        // Table: two hand vectors with known answers, then 16 states covering all byte values.
        vtab[0] = '{128'h00102030405060708090a0b0c0d0e0f0, 128'h63cab7040953d051cd60e0e7ba70e18c};
        vtab[1] = '{128'h00015352ff102030405060708090a0b0, 128'h637ced0016cab7040953d051cd60e0e7};
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) vtab[2+k].in_s[127-8*j -: 8] = 8'(k * 16 + j);
            vtab[2+k].exp_s = sub_m(vtab[2+k].in_s);
        end

        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        sw_in_valid = 1'b0; sw_in_state = '0; sw_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency of the reference vector at LANES=4 and busy/in_ready while processing.
        send(vtab[0].in_s, vtab[0].exp_s);
        chk("proc_busy", 128'(busy), 128'd1);
        chk("proc_in_ready", 128'(in_ready), 128'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency_l4", 128'(lat), 128'd4);
        chk("done_out_state", out_state, 128'h63cab7040953d051cd60e0e7ba70e18c);
        @(posedge clk); #1;
        chk("post_hs_out_valid", 128'(out_valid), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready), 128'd1);
        drain();

        // Table through the scoreboard.
        for (int i = 0; i < 18; i++) send(vtab[i].in_s, vtab[i].exp_s);
        drain();

        // Back-to-back issue interval with out_ready held high.
        send(vtab[1].in_s, vtab[1].exp_s); a0 = acc_cyc;
        send(vtab[2].in_s, vtab[2].exp_s); a1 = acc_cyc;
        chk("issue_interval_l4", 128'(a1 - a0), 128'd6);
        drain();

        // in_valid with other data during PROC and DONE is ignored.
        send(vtab[5].in_s, vtab[5].exp_s);
        out_ready = 1'b0; in_valid = 1'b1; in_state = vtab[9].in_s;
        bad = 0;
        repeat (6) begin @(posedge clk); #1; if (in_ready) bad++; end
        chk("ignore_in_ready_low", 128'(bad), 128'd0);
        chk("ignore_reached_done", 128'(out_valid), 128'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Backpressure: result held for 10 cycles.
        out_ready = 1'b0;
        send(vtab[7].in_s, vtab[7].exp_s);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        snap = out_state;
        chk("bp_value", snap, vtab[7].exp_s);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || out_state !== snap || in_ready || !busy) bad++;
        end
        chk("bp_hold", 128'(bad), 128'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        drain();

        // Asynchronous reset after 2 of 4 groups; nothing partial comes out.
        send(vtab[3].in_s, vtab[3].exp_s);
        @(posedge clk); @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_out_state", out_state, 128'd0);
        flushed += sbq.size();
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(vtab[1].in_s, vtab[1].exp_s);
        drain();
        chk("sb_count", 128'(popped), 128'(pushed - flushed));

        // LANES sweep: same vector, latency 16/LANES, identical result.
        for (int g = 0; g < 4; g++) begin sw_lat[g] = 0; sw_res[g] = '0; end
        sw_in_state = vtab[0].in_s; sw_in_valid = 1'b1;
        @(posedge clk); #1;
        sw_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++)
                if (sw_out_valid[g] && sw_lat[g] == 0) begin sw_lat[g] = k; sw_res[g] = sw_out_state[g]; end
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep_latency_l%0d", sw_ln(g)), 128'(sw_lat[g]), 128'(16 / sw_ln(g)));
            chk($sformatf("sweep_result_l%0d", sw_ln(g)), sw_res[g], vtab[0].exp_s);
        end

        // LANES sweep: back-to-back interval 16/LANES + 2.
        for (int g = 0; g < 4; g++) nacc[g] = 0;
        sw_in_valid = 1'b1; sw_in_state = vtab[4].in_s;
        for (int k = 0; k < 60; k++) begin
            for (int g = 0; g < 4; g++)
                if (sw_in_ready[g] && nacc[g] < 2) begin acc[g][nacc[g]] = k; nacc[g]++; end
            @(posedge clk); #1;
        end
        sw_in_valid = 1'b0;
        for (int g = 0; g < 4; g++)
            chk($sformatf("sweep_interval_l%0d", sw_ln(g)),
                128'((nacc[g] == 2) ? acc[g][1] - acc[g][0] : -1), 128'(16 / sw_ln(g) + 2));
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
